// File: rtl/qam16_pkg.sv
// Shared definitions for the 16-QAM receive path: per-axis level codes,
// symbol field positions, demapper FSM states and the saturation constant.
package qam16_pkg;

    localparam int unsigned AXIS_W = 2;
    localparam int unsigned SYM_W  = 4;

    // LSB position of each axis field inside a 4-bit symbol ([1:0] I, [3:2] Q)
    localparam int unsigned I_BITS = 0;
    localparam int unsigned Q_BITS = 2;

    localparam logic [AXIS_W-1:0] LVL_N3 = 2'b00;
    localparam logic [AXIS_W-1:0] LVL_N1 = 2'b01;
    localparam logic [AXIS_W-1:0] LVL_P1 = 2'b10;
    localparam logic [AXIS_W-1:0] LVL_P3 = 2'b11;

    // All-ones source; truncate with a width cast to get any counter's ceiling
    localparam logic [63:0] SAT_MAX = '1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/qam16_slice_axis.sv
// One-axis 4-level slicer: maps a signed sample against threshold thr (>= 0)
// to a 2-bit level code. Purely combinational.
//   x      : signed sample
//   thr    : signed decision threshold, caller guarantees thr >= 0
//   code_c : level code (00=-3a, 01=-a, 10=+a, 11=+3a)
module qam16_slice_axis
    import qam16_pkg::*;
#(
    parameter int unsigned WIDTH = 18
) (
    input  logic signed [WIDTH-1:0]  x,
    input  logic signed [WIDTH-1:0]  thr,
    output logic        [AXIS_W-1:0] code_c
);

    localparam logic signed [WIDTH:0] ZERO = '0;

    logic signed [WIDTH:0] x_ext;
    logic signed [WIDTH:0] thr_ext;
    logic signed [WIDTH:0] neg_thr;

    // One extra bit so -thr never overflows
    always_comb begin
        x_ext   = {x[WIDTH-1], x};
        thr_ext = {thr[WIDTH-1], thr};
        neg_thr = -thr_ext;
        code_c  = LVL_N3;
        if (x_ext >= thr_ext) begin
            code_c = LVL_P3;
        end else if (x_ext >= ZERO) begin
            code_c = LVL_P1;
        end else if (x_ext >= neg_thr) begin
            code_c = LVL_N1;
        end
    end

endmodule

// File: rtl/qam16_demapper.sv
// 16-QAM demapper: slices received I/Q into 4-bit symbols, compares them with
// the delayed transmit symbols and reports windowed, saturating error stats.
// Optional macro QAM16_DEMAP_BIT_ERR_EN adds bit-error counting; otherwise
// bit_err_cnt is tied to 0.
// Ports:
//   clk, reset (async, active-low), sym_en (symbol enable), i_in/q_in (samples),
//   ref_level (threshold 2a), tx_sym (transmit symbol), hold (window close),
//   sym_out/sym_valid (sliced symbol), err_now (last compare mismatch),
//   sym_err_cnt/sym_cnt/bit_err_cnt/cnt_valid (closed-window results).
module qam16_demapper
    import qam16_pkg::*;
#(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned SYM_DELAY = 4,
    parameter int unsigned CNT_W     = 22
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sym_en,
    input  logic signed [WIDTH-1:0] i_in,
    input  logic signed [WIDTH-1:0] q_in,
    input  logic signed [WIDTH-1:0] ref_level,
    input  logic        [SYM_W-1:0] tx_sym,
    input  logic                    hold,
    output logic        [SYM_W-1:0] sym_out,
    output logic                    sym_valid,
    output logic                    err_now,
    output logic        [CNT_W-1:0] sym_err_cnt,
    output logic        [CNT_W-1:0] sym_cnt,
    output logic        [CNT_W-1:0] bit_err_cnt,
    output logic                    cnt_valid
);

    localparam int unsigned      FILL_W  = $clog2(SYM_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAT_MAX);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    state_t                   state, state_nxt;
    logic [FILL_W-1:0]        fill_cnt, fill_nxt;
    logic [SYM_W-1:0]         sym_out_nxt;
    logic                     sym_valid_nxt, err_now_nxt, cnt_valid_nxt;
    logic [CNT_W-1:0]         acc_err, acc_err_nxt, acc_sym, acc_sym_nxt;
    logic [CNT_W-1:0]         err_cnt_nxt, sym_cnt_nxt, err_sum, sym_sum;
    logic signed [WIDTH-1:0]  thr_c;
    logic [AXIS_W-1:0]        i_code_c, q_code_c;
    logic [SYM_W-1:0]         dly_q [SYM_DELAY];
    logic [SYM_W-1:0]         tx_dly_c, diff_c;
    logic                     mismatch_c;

    // Negative reference collapses to a zero threshold
    assign thr_c = ref_level[WIDTH-1] ? '0 : ref_level;

    qam16_slice_axis #(.WIDTH(WIDTH)) u_slice_i (.x(i_in), .thr(thr_c), .code_c(i_code_c));
    qam16_slice_axis #(.WIDTH(WIDTH)) u_slice_q (.x(q_in), .thr(thr_c), .code_c(q_code_c));

    // Transmit-symbol delay line, advancing once per symbol
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYM_DELAY; k++) dly_q[k] <= '0;
        end else if (sym_en) begin
            dly_q[0] <= tx_sym;
            for (int k = 1; k < SYM_DELAY; k++) dly_q[k] <= dly_q[k-1];
        end
    end

    assign tx_dly_c   = dly_q[SYM_DELAY-1];
    assign diff_c     = sym_out ^ tx_dly_c;
    assign mismatch_c = |diff_c;

    // Next-state, slicer pipeline and window accumulation
    always_comb begin
        state_nxt     = state;
        fill_nxt      = fill_cnt;
        sym_out_nxt   = sym_out;
        sym_valid_nxt = 1'b0;
        err_now_nxt   = err_now;
        acc_err_nxt   = acc_err;
        acc_sym_nxt   = acc_sym;
        err_cnt_nxt   = sym_err_cnt;
        sym_cnt_nxt   = sym_cnt;
        cnt_valid_nxt = 1'b0;
        err_sum       = acc_err;
        sym_sum       = acc_sym;

        if (sym_en) begin
            sym_out_nxt[I_BITS +: AXIS_W] = i_code_c;
            sym_out_nxt[Q_BITS +: AXIS_W] = q_code_c;
            sym_valid_nxt                 = 1'b1;
            err_now_nxt                   = mismatch_c;
        end

        case (state)
            FILL: begin
                // Wait until delay line and slicer hold real data
                if (sym_en) begin
                    if (fill_cnt == FILL_W'(SYM_DELAY)) begin
                        state_nxt = RUN;
                        fill_nxt  = '0;
                    end else begin
                        fill_nxt = fill_cnt + FILL_W'(1);
                    end
                end
            end
            RUN: begin
                if (sym_en) begin
                    err_sum = sat_add(acc_err, {2'b00, mismatch_c});
                    sym_sum = sat_add(acc_sym, 3'd1);
                end
                // A compare on the closing edge belongs to the closing window
                if (hold) begin
                    err_cnt_nxt   = err_sum;
                    sym_cnt_nxt   = sym_sum;
                    cnt_valid_nxt = 1'b1;
                    acc_err_nxt   = '0;
                    acc_sym_nxt   = '0;
                end else begin
                    acc_err_nxt = err_sum;
                    acc_sym_nxt = sym_sum;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            fill_cnt    <= '0;
            sym_out     <= '0;
            sym_valid   <= 1'b0;
            err_now     <= 1'b0;
            acc_err     <= '0;
            acc_sym     <= '0;
            sym_err_cnt <= '0;
            sym_cnt     <= '0;
            cnt_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            fill_cnt    <= fill_nxt;
            sym_out     <= sym_out_nxt;
            sym_valid   <= sym_valid_nxt;
            err_now     <= err_now_nxt;
            acc_err     <= acc_err_nxt;
            acc_sym     <= acc_sym_nxt;
            sym_err_cnt <= err_cnt_nxt;
            sym_cnt     <= sym_cnt_nxt;
            cnt_valid   <= cnt_valid_nxt;
        end
    end

`ifdef QAM16_DEMAP_BIT_ERR_EN
    logic [CNT_W-1:0] acc_bit, acc_bit_nxt, bit_cnt_q, bit_cnt_nxt, bit_sum;
    logic [2:0]       pop_c;

    // Hamming distance between sliced and delayed transmit symbol
    assign pop_c = 3'(diff_c[0]) + 3'(diff_c[1]) + 3'(diff_c[2]) + 3'(diff_c[3]);

    // Bit-error window, same timing as the symbol-error window
    always_comb begin
        acc_bit_nxt = acc_bit;
        bit_cnt_nxt = bit_cnt_q;
        bit_sum     = acc_bit;
        if (state == RUN) begin
            if (sym_en) bit_sum = sat_add(acc_bit, pop_c);
            if (hold) begin
                bit_cnt_nxt = bit_sum;
                acc_bit_nxt = '0;
            end else begin
                acc_bit_nxt = bit_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_bit   <= '0;
            bit_cnt_q <= '0;
        end else begin
            acc_bit   <= acc_bit_nxt;
            bit_cnt_q <= bit_cnt_nxt;
        end
    end

    assign bit_err_cnt = bit_cnt_q;
`else
    assign bit_err_cnt = '0;
`endif

endmodule

// File: tb/tb_qam16_demapper.sv
// Self-checking bench for qam16_demapper with a queue-based reference model.
`timescale 1ns/1ps
module tb_qam16_demapper;

    localparam int unsigned W    = 18;
    localparam int unsigned SD   = 4;
    localparam int unsigned CW   = 10;
    localparam int          A    = 4096;
    localparam int          MAXC = (1 << CW) - 1;

    logic                clk;
    logic                reset;
    logic                sym_en;
    logic signed [W-1:0] i_in, q_in, ref_level;
    logic [3:0]          tx_sym;
    logic                hold;
    logic [3:0]          sym_out;
    logic                sym_valid, err_now, cnt_valid;
    logic [CW-1:0]       sym_err_cnt, sym_cnt, bit_err_cnt;

    qam16_demapper #(.WIDTH(W), .SYM_DELAY(SD), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .sym_en(sym_en), .i_in(i_in), .q_in(q_in),
        .ref_level(ref_level), .tx_sym(tx_sym), .hold(hold), .sym_out(sym_out),
        .sym_valid(sym_valid), .err_now(err_now), .sym_err_cnt(sym_err_cnt),
        .sym_cnt(sym_cnt), .bit_err_cnt(bit_err_cnt), .cnt_valid(cnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         ticks, ref_int;
    logic [3:0] tx_q[$];
    logic [3:0] sent[$];
    logic [3:0] m_sym;
    int         w_err, w_sym, w_bit;
    logic [3:0] e_sym_out;
    logic       e_sym_valid, e_err_now, e_cnt_valid;
    int         e_err_cnt, e_sym_cnt, e_bit_cnt;

    function automatic logic [1:0] lvl(input int x, input int r);
        int t;
        t = (r > 0) ? r : 0;
        if (x >= t)  return 2'd3;
        if (x >= 0)  return 2'd2;
        if (x >= -t) return 2'd1;
        return 2'd0;
    endfunction

    function automatic int lv(input logic [1:0] c);
        return (2 * int'(c) - 3) * A;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_reset();
        ticks = 0;
        tx_q.delete();
        for (int k = 0; k < int'(SD); k++) tx_q.push_back(4'h0);
        sent.delete();
        m_sym = 4'h0;
        w_err = 0; w_sym = 0; w_bit = 0;
        e_sym_out = 4'h0; e_sym_valid = 1'b0; e_err_now = 1'b0; e_cnt_valid = 1'b0;
        e_err_cnt = 0; e_sym_cnt = 0; e_bit_cnt = 0;
    endtask

    // Drive one clock with the given inputs, predicting the post-edge outputs
    task automatic step(input int iv, input int qv, input logic [3:0] tx,
                        input bit se, input bit hd);
        logic [3:0] txd;
        bit         run;
        run       = (ticks >= int'(SD) + 1);
        i_in      = W'(iv);
        q_in      = W'(qv);
        ref_level = W'(ref_int);
        tx_sym    = tx;
        sym_en    = se;
        hold      = hd;
        e_sym_valid = se;
        e_cnt_valid = 1'b0;
        if (se) begin
            txd = tx_q.pop_front();
            tx_q.push_back(tx);
            e_err_now = (m_sym != txd);
            if (run) begin
                w_sym++;
                w_err += int'(m_sym != txd);
                w_bit += $countones(m_sym ^ txd);
            end
            m_sym = {lvl(qv, ref_int), lvl(iv, ref_int)};
            e_sym_out = m_sym;
            ticks++;
        end
        if (hd && run) begin
            e_err_cnt = sat(w_err);
            e_sym_cnt = sat(w_sym);
`ifdef QAM16_DEMAP_BIT_ERR_EN
            e_bit_cnt = sat(w_bit);
`else
            e_bit_cnt = 0;
`endif
            e_cnt_valid = 1'b1;
            w_err = 0; w_sym = 0; w_bit = 0;
        end
        @(posedge clk);
        #1;
        sym_en = 1'b0;
        hold   = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 1'b0, 1'b0);
    endtask

    // Loopback symbol: received I/Q carries the symbol sent SD-1 ticks earlier, Q optionally corrupted
    task automatic lb_tick(input logic [1:0] qmask, input bit hd);
        logic [3:0] x, s;
        x = 4'($urandom_range(0, 15));
        sent.push_back(x);
        if (sent.size() > int'(SD)) void'(sent.pop_front());
        s = (sent.size() == int'(SD)) ? sent[0] : 4'($urandom_range(0, 15));
        s[3:2] = s[3:2] ^ qmask;
        step(lv(s[1:0]), lv(s[3:2]), x, 1'b1, hd);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; sym_en = 1'b0; hold = 1'b0; tx_sym = 4'h0;
        i_in = '0; q_in = '0; ref_level = '0; ref_int = 8192;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sym_out, sym_valid, err_now, sym_err_cnt, sym_cnt, bit_err_cnt, cnt_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0",
                     {sym_out, sym_valid, err_now, sym_err_cnt, sym_cnt, bit_err_cnt, cnt_valid});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_slice();
        int         bi [5];
        logic [1:0] bc [5];
        int         iv, qv;
        bi = '{8192, 0, -8192, -8193, 8191};
        bc = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd2};
        ref_int = 8192;
        step(12288, -4096, 4'h0, 1'b1, 1'b0);
        n_checks++;
        if (sym_out !== 4'b0111) begin
            n_fail++; $display("FAIL slice_directed sym_out got=%b exp=0111", sym_out);
        end
        n_checks++;
        if (sym_valid !== 1'b1) begin
            n_fail++; $display("FAIL sym_valid_pulse got=%b exp=1", sym_valid);
        end
        idle();
        n_checks++;
        if (sym_valid !== 1'b0 || sym_out !== 4'b0111) begin
            n_fail++; $display("FAIL sym_valid_drop valid=%b sym=%b exp 0/0111", sym_valid, sym_out);
        end
        for (int k = 0; k < 5; k++) begin
            step(bi[k], 0, 4'h0, 1'b1, 1'b0);
            n_checks++;
            if (sym_out !== {2'b10, bc[k]}) begin
                n_fail++;
                $display("FAIL slice_boundary I=%0d got=%b exp=%b", bi[k], sym_out, {2'b10, bc[k]});
            end
            idle();
        end
        for (int k = 0; k < 40; k++) begin
            ref_int = (k % 5 == 4) ? -int'($urandom_range(1, 1000)) : int'($urandom_range(0, 40000));
            iv = int'($urandom_range(0, 262143)) - 131072;
            qv = int'($urandom_range(0, 262143)) - 131072;
            step(iv, qv, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            n_checks++;
            if (sym_out !== e_sym_out || err_now !== e_err_now) begin
                n_fail++;
                $display("FAIL slice_random ref=%0d I=%0d Q=%0d got sym=%b err=%b exp sym=%b err=%b",
                         ref_int, iv, qv, sym_out, err_now, e_sym_out, e_err_now);
            end
            idle();
        end
    endtask

    task automatic test_loopback();
        apply_reset();
        ref_int = 8192;
        for (int k = 0; k < 100; k++) begin
            lb_tick(2'b00, 1'b0);
            idle();
        end
        step(0, 0, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (cnt_valid !== 1'b1 || sym_cnt !== CW'(100 - (SD + 1)) || sym_err_cnt !== '0
            || bit_err_cnt !== '0) begin
            n_fail++;
            $display("FAIL loopback_window valid=%b sym_cnt=%0d err=%0d bit=%0d exp 1/%0d/0/0",
                     cnt_valid, sym_cnt, sym_err_cnt, bit_err_cnt, 100 - (SD + 1));
        end
        idle();
        n_checks++;
        if (cnt_valid !== 1'b0 || sym_cnt !== CW'(e_sym_cnt)) begin
            n_fail++;
            $display("FAIL loopback_hold_outputs valid=%b sym_cnt=%0d exp 0/%0d", cnt_valid, sym_cnt, e_sym_cnt);
        end
    endtask

    task automatic test_q_errors();
        int seen;
        seen = 0;
        for (int j = 0; j < 1000; j++) begin
            lb_tick((j % 10 == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b0);
            n_checks++;
            if (err_now !== e_err_now) begin
                n_fail++; $display("FAIL q_err_now tick=%0d got=%b exp=%b", j, err_now, e_err_now);
            end
            if (err_now === 1'b1) seen++;
            idle();
        end
        step(0, 0, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (cnt_valid !== 1'b1 || sym_err_cnt !== CW'(100) || sym_cnt !== CW'(1000)) begin
            n_fail++;
            $display("FAIL q_err_window valid=%b err=%0d sym=%0d exp 1/100/1000", cnt_valid, sym_err_cnt, sym_cnt);
        end
        n_checks++;
        if (bit_err_cnt !== CW'(e_bit_cnt)) begin
            n_fail++; $display("FAIL q_bit_err got=%0d exp=%0d", bit_err_cnt, e_bit_cnt);
        end
        n_checks++;
        if (seen != 100) begin
            n_fail++; $display("FAIL q_err_now_count got=%0d exp=100", seen);
        end
    endtask

    task automatic test_saturation();
        for (int j = 0; j < 1100; j++) begin
            lb_tick(2'b11, 1'b0);
            idle();
        end
        step(0, 0, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (sym_err_cnt !== CW'(MAXC) || sym_cnt !== CW'(MAXC)) begin
            n_fail++;
            $display("FAIL saturation err=%0d sym=%0d exp %0d/%0d", sym_err_cnt, sym_cnt, MAXC, MAXC);
        end
        n_checks++;
        if (bit_err_cnt !== CW'(e_bit_cnt)) begin
            n_fail++; $display("FAIL saturation_bit got=%0d exp=%0d", bit_err_cnt, e_bit_cnt);
        end
    endtask

    task automatic test_hold_same_clk();
        lb_tick(2'b00, 1'b0);
        step(0, 0, 4'h0, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            lb_tick(2'b00, 1'b0);
            idle();
        end
        lb_tick(2'b01, 1'b0);
        idle();
        lb_tick(2'b00, 1'b1);
        n_checks++;
        if (cnt_valid !== 1'b1 || err_now !== 1'b1 || sym_err_cnt !== CW'(1) || sym_cnt !== CW'(7)) begin
            n_fail++;
            $display("FAIL hold_same_clk valid=%b err_now=%b err=%0d sym=%0d exp 1/1/1/7",
                     cnt_valid, err_now, sym_err_cnt, sym_cnt);
        end
        n_checks++;
        if (bit_err_cnt !== CW'(e_bit_cnt)) begin
            n_fail++; $display("FAIL hold_same_clk_bit got=%0d exp=%0d", bit_err_cnt, e_bit_cnt);
        end
        idle();
        for (int j = 0; j < 5; j++) begin
            lb_tick(2'b00, 1'b0);
            idle();
        end
        step(0, 0, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (cnt_valid !== 1'b1 || sym_err_cnt !== '0 || sym_cnt !== CW'(5) || bit_err_cnt !== '0) begin
            n_fail++;
            $display("FAIL next_window_clean valid=%b err=%0d sym=%0d bit=%0d exp 1/0/5/0",
                     cnt_valid, sym_err_cnt, sym_cnt, bit_err_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int j = 0; j < 3; j++) begin
            lb_tick(2'b00, 1'b0);
            idle();
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({sym_out, sym_valid, err_now, sym_err_cnt, sym_cnt, bit_err_cnt, cnt_valid} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=0",
                     {sym_out, sym_valid, err_now, sym_err_cnt, sym_cnt, bit_err_cnt, cnt_valid});
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        lb_tick(2'b00, 1'b0);
        idle();
        lb_tick(2'b00, 1'b1);
        n_checks++;
        if (cnt_valid !== 1'b0 || sym_cnt !== '0) begin
            n_fail++; $display("FAIL hold_in_fill valid=%b sym=%0d exp 0/0", cnt_valid, sym_cnt);
        end
        idle();
        for (int j = 0; j < 6; j++) begin
            lb_tick(2'b00, 1'b0);
            idle();
        end
        step(0, 0, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (cnt_valid !== 1'b1 || sym_cnt !== CW'(3) || sym_err_cnt !== '0) begin
            n_fail++;
            $display("FAIL post_reset_window valid=%b sym=%0d err=%0d exp 1/3/0", cnt_valid, sym_cnt, sym_err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_slice();
        test_loopback();
        test_q_errors();
        test_saturation();
        test_hold_same_clk();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
